// File: rtl/step_window_counter.sv
// step_window_counter
//   Counts step pulses within each one-second interval. A second "qualifies"
//   when its step count reaches THRESH. Reports how many seconds qualified
//   over an observation window, either as a one-shot session (MODE 0) or as
//   a sliding window over the last WINDOW seconds (MODE 1).
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   pulse          raw step pulse, asynchronous, high for >= 2 clk cycles
//   sec_tick       one-cycle end-of-second strobe, synchronous to clk
//   enable         low: steps and ticks ignored, all state holds
//   over_count     qualified seconds in the window
//   last_sec_steps saturated step count of the most recently closed second
//   over_flag      one-cycle strobe, the second that just closed qualified
//   window_done    sticky, WINDOW ticks have elapsed since reset
module step_window_counter #(
  parameter int THRESH = 32,
  parameter int WINDOW = 10,
  parameter int CNT_W  = 6,
  parameter int OUT_W  = 14,
  parameter int MODE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse,
  input  logic             sec_tick,
  input  logic             enable,
  output logic [OUT_W-1:0] over_count,
  output logic [CNT_W-1:0] last_sec_steps,
  output logic             over_flag,
  output logic             window_done
);

  localparam int EL_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // s1/s2 form the synchroniser, s3 holds the previous synchronised level
  logic s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cur_cnt_q, cur_cnt_d;
  logic [EL_W-1:0]  elapsed_q;
  logic [OUT_W-1:0] over_count_q, over_count_d;
  logic [CNT_W-1:0] last_q;
  logic             flag_q, done_q;

  logic             step, tick, qualify, win_full, drop, cnt_upd;
  logic [CNT_W-1:0] closing;

  assign step     = s2_q & ~s3_q & enable;
  assign tick     = sec_tick & enable;
  assign win_full = (elapsed_q == EL_W'(WINDOW));

  // A step coincident with the tick belongs to the closing second
  assign closing  = (step && cur_cnt_q != CNT_MAX) ? cur_cnt_q + 1'b1 : cur_cnt_q;
  assign qualify  = (closing >= CNT_W'(THRESH));

  generate
    if (MODE == 1) begin : g_slide
      logic [WINDOW-1:0] hist_q;
      always_ff @(posedge clk) begin
        if (reset)     hist_q <= '0;
        else if (tick) hist_q <= {hist_q[WINDOW-2:0], qualify};
      end
      // bit leaving the window was counted when it entered, so no underflow
      assign drop    = hist_q[WINDOW-1];
      assign cnt_upd = 1'b1;
    end else begin : g_shot
      assign drop    = 1'b0;
      assign cnt_upd = ~win_full;
    end
  endgenerate

  always_comb begin
    cur_cnt_d = cur_cnt_q;
    if (tick)
      cur_cnt_d = '0;
    else if (step && cur_cnt_q != CNT_MAX)
      cur_cnt_d = cur_cnt_q + 1'b1;
  end

  always_comb begin
    over_count_d = over_count_q;
    if (tick && cnt_upd)
      over_count_d = over_count_q + OUT_W'(qualify) - OUT_W'(drop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cur_cnt_q    <= '0;
      elapsed_q    <= '0;
      over_count_q <= '0;
      last_q       <= '0;
      flag_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // synchroniser keeps running regardless of enable
      s1_q         <= pulse;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      cur_cnt_q    <= cur_cnt_d;
      over_count_q <= over_count_d;
      flag_q       <= tick & qualify;
      if (tick) begin
        last_q <= closing;
        if (!win_full) elapsed_q <= elapsed_q + 1'b1;
        if (elapsed_q >= EL_W'(WINDOW - 1)) done_q <= 1'b1;
      end
    end
  end

  assign over_count     = over_count_q;
  assign last_sec_steps = last_q;
  assign over_flag      = flag_q;
  assign window_done    = done_q;

endmodule

// File: tb/tb_step_window_counter.sv
// Directed bench: dut0 uses defaults (MODE 0, WINDOW 10), dut1 is a
// sliding-window instance with WINDOW 4. Both share stimulus.
module tb_step_window_counter;

  logic clk = 1'b0;
  logic reset = 1'b1, pulse = 1'b0, sec_tick = 1'b0, enable = 1'b1;

  logic [13:0] oc0, oc1;
  logic [5:0]  ls0, ls1;
  logic        of0, of1, wd0, wd1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  step_window_counter dut0 (
    .clk(clk), .reset(reset), .pulse(pulse), .sec_tick(sec_tick), .enable(enable),
    .over_count(oc0), .last_sec_steps(ls0), .over_flag(of0), .window_done(wd0));

  step_window_counter #(.WINDOW(4), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .pulse(pulse), .sec_tick(sec_tick), .enable(enable),
    .over_count(oc1), .last_sec_steps(ls1), .over_flag(of1), .window_done(wd1));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one step: 2 cycles high, 2 low; fully counted by the end of the task
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) pulse = 1'b1;
      @(negedge clk);
      @(negedge clk) pulse = 1'b0;
      @(negedge clk);
    end
  endtask

  // tick for one cycle; returns at the negedge after outputs update
  task automatic tick();
    @(negedge clk) sec_tick = 1'b1;
    @(negedge clk) sec_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  int m0_steps [11] = '{40, 5, 32, 31, 33, 0, 50, 32, 1, 40, 40};
  int m0_cnt   [11] = '{1, 1, 2, 2, 3, 3, 4, 5, 5, 6, 6};
  int m0_flag  [11] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 1};
  int m1_steps [6]  = '{40, 40, 0, 0, 0, 40};
  int m1_cnt   [6]  = '{1, 2, 2, 2, 1, 1};

  initial begin
    // reset state
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk("rst_count", oc0, 0);
    chk("rst_last",  ls0, 0);
    chk("rst_flag",  of0, 0);
    chk("rst_done",  wd0, 0);

    // MODE 0 session, plus an 11th second after the window closes
    for (int s = 0; s < 11; s++) begin
      steps(m0_steps[s]);
      tick();
      chk($sformatf("m0_count_t%0d", s + 1), oc0, m0_cnt[s]);
      chk($sformatf("m0_last_t%0d", s + 1),  ls0, m0_steps[s]);
      chk($sformatf("m0_flag_t%0d", s + 1),  of0, m0_flag[s]);
      chk($sformatf("m0_done_t%0d", s + 1),  wd0, (s >= 9) ? 1 : 0);
      @(negedge clk);
      chk($sformatf("m0_flag_drop_t%0d", s + 1), of0, 0);
    end

    // MODE 1 sliding window of 4
    do_reset();
    for (int s = 0; s < 6; s++) begin
      steps(m1_steps[s]);
      tick();
      chk($sformatf("m1_count_t%0d", s + 1), oc1, m1_cnt[s]);
    end

    // saturation
    do_reset();
    steps(70);
    tick();
    chk("sat_last", ls0, 63);
    chk("sat_flag", of0, 1);
    chk("sat_count", oc0, 1);

    // enable low: nothing moves
    @(negedge clk) enable = 1'b0;
    steps(40);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("en0_flag", of0, 0);
    end
    chk("en0_count", oc0, 1);
    chk("en0_last",  ls0, 63);
    chk("en0_done",  wd0, 0);
    @(negedge clk) enable = 1'b1;
    tick();
    chk("en0_steps_lost", ls0, 0);
    chk("en0_count_after", oc0, 1);

    // coincidence: 32nd step edge arrives in the tick cycle
    do_reset();
    steps(31);
    @(negedge clk) pulse = 1'b1;
    @(negedge clk);
    @(negedge clk) begin pulse = 1'b0; sec_tick = 1'b1; end
    @(negedge clk) sec_tick = 1'b0;
    chk("coin_last", ls0, 32);
    chk("coin_flag", of0, 1);
    tick();
    chk("coin_cnt_cleared", ls0, 0);

    // reset mid-window with simultaneous tick
    do_reset();
    for (int s = 0; s < 5; s++) begin
      steps(33);
      tick();
    end
    chk("mid_count", oc0, 5);
    @(negedge clk) begin reset = 1'b1; sec_tick = 1'b1; end
    @(negedge clk) begin reset = 1'b0; sec_tick = 1'b0; end
    chk("mid_rst_count", oc0, 0);
    chk("mid_rst_last",  ls0, 0);
    chk("mid_rst_flag",  of0, 0);
    chk("mid_rst_done",  wd0, 0);
    for (int t = 0; t < 9; t++) tick();
    chk("mid_done_9", wd0, 0);
    tick();
    chk("mid_done_10", wd0, 1);
    chk("mid_count_end", oc0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // hard bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
